mips_intc: RTL and testbench



---
 rtl/mips_intc_pkg.sv | 15 +
 rtl/mips_intc_prio.sv | 25 ++
 rtl/mips_intc.sv | 132 +++++++++++++
 tb/tb_mips_intc.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_intc_pkg.sv
// Shared constants for the MIPS interrupt controller: line count,
// register offsets (Addr[4:2]) and the VEC valid bit position.
package mips_intc_pkg;

    localparam int INTC_NIRQ = 6;

    localparam logic [2:0] INTC_MASK = 3'd0;
    localparam logic [2:0] INTC_MODE = 3'd1;
    localparam logic [2:0] INTC_PEND = 3'd2;
    localparam logic [2:0] INTC_ISR  = 3'd3;
    localparam logic [2:0] INTC_VEC  = 3'd4;

    localparam int VEC_VALID_BIT = 31;

endpackage

// File: rtl/mips_intc_prio.sv
// Lowest-index-first priority encoder.
// Ports: req (N-bit request), idx (3-bit lowest set index), valid (any set).
module mips_intc_prio
    import mips_intc_pkg::*;
#(
    parameter int N = INTC_NIRQ
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         valid
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_intc.sv
// Programmable interrupt controller: edge/level pending, mask, nested ISR.
// Ports: clk, reset, WE/Addr/WD/RD bridge slot, IRQ lines in, HWInt one-hot out.
module mips_intc
    import mips_intc_pkg::*;
#(
    parameter int NIRQ = INTC_NIRQ
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            WE,
    input  logic [31:0]     Addr,
    input  logic [31:0]     WD,
    output logic [31:0]     RD,
    input  logic [NIRQ-1:0] IRQ,
    output logic [NIRQ-1:0] HWInt
);

    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] irq_qq;
    logic [NIRQ-1:0] mask;
    logic [NIRQ-1:0] mode;
    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] isr;

    logic [2:0]      sel;
    logic [2:0]      cand_idx;
    logic            cand_vld;
    logic [2:0]      isr_idx;
    logic            isr_vld;
    logic            win_vld;
    logic [NIRQ-1:0] win_oh;
    logic [NIRQ-1:0] isr_oh;
    logic            ack;
    logic            eoi;
    logic            pend_w1c;
    logic [NIRQ-1:0] edge_set;
    logic [NIRQ-1:0] pend_clr;
    logic [NIRQ-1:0] pend_next;
    logic [NIRQ-1:0] isr_next;

    logic            unused_bits;

    assign sel = Addr[4:2];

    assign unused_bits = ^{Addr[31:5], Addr[1:0], WD[31:NIRQ]};

    mips_intc_prio #(.N(NIRQ)) u_cand (
        .req   (pend & mask),
        .idx   (cand_idx),
        .valid (cand_vld)
    );

    mips_intc_prio #(.N(NIRQ)) u_isr (
        .req   (isr),
        .idx   (isr_idx),
        .valid (isr_vld)
    );

    // A candidate only wins if strictly above the highest in-service level.
    assign win_vld = cand_vld && (!isr_vld || (cand_idx < isr_idx));

    assign win_oh = {{(NIRQ-1){1'b0}}, 1'b1} << cand_idx;
    assign isr_oh = {{(NIRQ-1){1'b0}}, 1'b1} << isr_idx;

    assign ack      = WE && (sel == INTC_VEC) && win_vld;
    assign eoi      = WE && (sel == INTC_ISR) && isr_vld;
    assign pend_w1c = WE && (sel == INTC_PEND);

    // Edge-mode lines: a new edge beats any clear in the same cycle.
    always_comb begin
        edge_set  = irq_q & ~irq_qq;
        pend_clr  = '0;
        if (pend_w1c) begin
            pend_clr = pend_clr | WD[NIRQ-1:0];
        end
        if (ack) begin
            pend_clr = pend_clr | win_oh;
        end
        pend_next = (~mode & irq_q)
                  | (mode & (edge_set | (pend & ~pend_clr)));
    end

    always_comb begin
        isr_next = isr;
        if (ack) begin
            isr_next = isr_next | win_oh;
        end
        if (eoi) begin
            isr_next = isr_next & ~isr_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q  <= '0;
            irq_qq <= '0;
            mask   <= '0;
            mode   <= '0;
            pend   <= '0;
            isr    <= '0;
            HWInt  <= '0;
        end else begin
            irq_q  <= IRQ;
            irq_qq <= irq_q;
            pend   <= pend_next;
            isr    <= isr_next;
            HWInt  <= win_vld ? win_oh : '0;
            if (WE && (sel == INTC_MASK)) begin
                mask <= WD[NIRQ-1:0];
            end
            if (WE && (sel == INTC_MODE)) begin
                mode <= WD[NIRQ-1:0];
            end
        end
    end

    always_comb begin
        RD = '0;
        case (sel)
            INTC_MASK: RD[NIRQ-1:0] = mask;
            INTC_MODE: RD[NIRQ-1:0] = mode;
            INTC_PEND: RD[NIRQ-1:0] = pend;
            INTC_ISR:  RD[NIRQ-1:0] = isr;
            INTC_VEC: begin
                RD[VEC_VALID_BIT] = win_vld;
                RD[2:0]           = win_vld ? cand_idx : 3'd0;
            end
            default:   RD = '0;
        endcase
    end

endmodule

// File: tb/tb_mips_intc.sv
// Self-checking bench for mips_intc: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the controller.
module tb_mips_intc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        WE = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WD = 32'h0;
    logic [31:0] RD;
    logic [5:0]  IRQ = 6'h0;
    logic [5:0]  HWInt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_intc dut (
        .clk   (clk),
        .reset (reset),
        .WE    (WE),
        .Addr  (Addr),
        .WD    (WD),
        .RD    (RD),
        .IRQ   (IRQ),
        .HWInt (HWInt)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    // Behavioural model
    bit [5:0] m_q, m_qq, m_mask, m_mode, m_pend, m_isr, m_hw;
    bit       started = 1'b0;

    function automatic void m_winner(output int w, output bit v);
        int lo_isr;
        lo_isr = 6;
        for (int i = 5; i >= 0; i--) if (m_isr[i]) lo_isr = i;
        w = 6;
        for (int i = 5; i >= 0; i--) if (m_pend[i] && m_mask[i]) w = i;
        v = (w < 6) && (w < lo_isr);
        if (!v) w = 0;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] off);
        int w;
        bit v;
        m_winner(w, v);
        case (off)
            3'd0: return {26'h0, m_mask};
            3'd1: return {26'h0, m_mode};
            3'd2: return {26'h0, m_pend};
            3'd3: return {26'h0, m_isr};
            3'd4: return v ? (32'h80000000 | 32'(w)) : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step();
        int       w;
        bit       v;
        bit [5:0] np, ni, nm, nmo;
        logic [2:0] off;
        if (reset) begin
            m_q = 0; m_qq = 0; m_mask = 0; m_mode = 0;
            m_pend = 0; m_isr = 0; m_hw = 0;
            started = 1'b1;
            return;
        end
        m_winner(w, v);
        off = Addr[4:2];
        nm = m_mask; nmo = m_mode; ni = m_isr;
        if (WE) begin
            case (off)
                3'd0: nm = WD[5:0];
                3'd1: nmo = WD[5:0];
                3'd3: begin
                    for (int i = 0; i < 6; i++) begin
                        if (m_isr[i]) begin
                            ni[i] = 1'b0;
                            break;
                        end
                    end
                end
                3'd4: if (v) ni[w] = 1'b1;
                default: ;
            endcase
        end
        for (int i = 0; i < 6; i++) begin
            if (!m_mode[i]) np[i] = m_q[i];
            else if (m_q[i] && !m_qq[i]) np[i] = 1'b1;
            else if ((WE && off == 3'd2 && WD[i]) ||
                     (WE && off == 3'd4 && v && w == i)) np[i] = 1'b0;
            else np[i] = m_pend[i];
        end
        m_hw   = v ? (6'd1 << w) : 6'd0;
        m_qq   = m_q;
        m_q    = IRQ;
        m_pend = np;
        m_isr  = ni;
        m_mask = nm;
        m_mode = nmo;
    endtask

    always @(posedge clk) begin
        m_step();
        #1;
        if (started) begin
            check("hwint_model", {26'h0, HWInt}, {26'h0, m_hw});
            check("rd_model", RD, m_rd(Addr[4:2]));
        end
    end

    // Stimulus helpers: the main thread always sits just after a negedge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] data);
        WE   = 1'b1;
        Addr = {27'h0, off, 2'b00};
        WD   = data;
        @(negedge clk);
        WE   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] off,
                          input logic [31:0] exp);
        Addr = {27'h0, off, 2'b00};
        #1;
        check(name, RD, exp);
    endtask

    task automatic hw_chk(input string name, input logic [5:0] exp);
        check(name, {26'h0, HWInt}, {26'h0, exp});
    endtask

    task automatic pulse(input logic [5:0] lines);
        IRQ = lines;
        tick(1);
        IRQ = 6'h0;
        tick(2);
    endtask

    initial begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd_chk("reset_rd", 3'(i), 32'h0);
            hw_chk("reset_hw", 6'h0);
            tick(1);
        end

        // Edge pulse on line 0, latency and ACK
        wr(3'd0, 32'h3);
        wr(3'd1, 32'h3);
        IRQ = 6'h01;
        tick(1);
        IRQ = 6'h00;
        tick(1);
        hw_chk("lat_t2", 6'h00);
        tick(1);
        hw_chk("lat_t3", 6'h01);
        rd_chk("vec_valid", 3'd4, 32'h80000000);
        tick(1);
        wr(3'd4, 32'h0);
        hw_chk("ack_lag", 6'h01);
        rd_chk("ack_isr", 3'd3, 32'h1);
        tick(1);
        rd_chk("ack_pend", 3'd2, 32'h0);
        hw_chk("ack_hw0", 6'h00);
        wr(3'd3, 32'h0);
        rd_chk("eoi_isr", 3'd3, 32'h0);
        tick(1);

        // Nesting: line 0 preempts line 1, line 1 blocked until two EOIs
        pulse(6'h02);
        hw_chk("l1_req", 6'h02);
        wr(3'd4, 32'h0);
        tick(1);
        hw_chk("l1_acked", 6'h00);
        pulse(6'h01);
        hw_chk("preempt", 6'h01);
        wr(3'd4, 32'h0);
        pulse(6'h02);
        tick(2);
        hw_chk("blocked", 6'h00);
        rd_chk("blocked_pend", 3'd2, 32'h2);
        tick(1);
        wr(3'd3, 32'h0);
        tick(1);
        hw_chk("eoi1_blocked", 6'h00);
        rd_chk("eoi1_isr", 3'd3, 32'h2);
        tick(1);
        wr(3'd3, 32'h0);
        tick(1);
        hw_chk("eoi2_release", 6'h02);
        wr(3'd4, 32'h0);
        wr(3'd3, 32'h0);

        // Level mode on line 1
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h2);
        IRQ = 6'h02;
        tick(3);
        hw_chk("lvl_hw", 6'h02);
        rd_chk("lvl_pend", 3'd2, 32'h2);
        tick(1);
        wr(3'd4, 32'h0);
        tick(1);
        rd_chk("lvl_ack_pend", 3'd2, 32'h2);
        hw_chk("lvl_ack_hw", 6'h00);
        tick(1);
        IRQ = 6'h00;
        tick(1);
        rd_chk("lvl_drop1", 3'd2, 32'h2);
        tick(1);
        rd_chk("lvl_drop2", 3'd2, 32'h0);
        tick(1);
        wr(3'd3, 32'h0);

        // Set wins over W1C
        wr(3'd1, 32'h1);
        wr(3'd0, 32'h1);
        IRQ = 6'h01;
        tick(1);
        IRQ = 6'h00;
        wr(3'd2, 32'h1);
        rd_chk("set_wins", 3'd2, 32'h1);
        tick(1);
        wr(3'd2, 32'h1);
        rd_chk("w1c", 3'd2, 32'h0);
        tick(1);

        // Simultaneous edges, then masking
        wr(3'd1, 32'h3);
        wr(3'd0, 32'h3);
        pulse(6'h03);
        hw_chk("simul", 6'h01);
        wr(3'd4, 32'h0);
        wr(3'd3, 32'h0);
        tick(1);
        hw_chk("simul_next", 6'h02);
        wr(3'd0, 32'h1);
        hw_chk("mask_lag", 6'h02);
        tick(1);
        hw_chk("masked", 6'h00);
        rd_chk("masked_pend", 3'd2, 32'h2);
        tick(1);

        // Random traffic
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0)
                IRQ = IRQ ^ (6'd1 << $urandom_range(0, 5));
            WE   = ($urandom_range(0, 3) == 0);
            Addr = {$urandom} & 32'hFFFF_FFFF;
            if ($urandom_range(0, 1) == 0)
                Addr[4:2] = 3'($urandom_range(2, 4));
            WD   = $urandom;
            tick(1);
        end
        reset = 1'b0;
        WE = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
